mbist_sig_shifter: RTL and testbench

MBIST_SIG_SHIFTER -- requirements
Module: mbist_sig_shifter

---
 rtl/mbist_sig_shifter_if.sv | 32 +++
 rtl/mbist_sig_shifter.sv | 118 +++++++++++
 tb/tb_mbist_sig_shifter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mbist_sig_shifter_if.sv
`default_nettype none
// ============================================================================
// Module      : mbist_sig_shifter_if
// Description : Capture/shift/status bundle between the BIST serial read
//               master and the signature shift register.
// Revision    : 1.0 - initial release
// ============================================================================
interface mbist_sig_shifter_if #(
    parameter int SIG_W = 64
);
    logic             sig_capture;
    logic [SIG_W-1:0] sig_data;
    logic             bist_shift;
    logic             bist_sdi;
    logic             bist_sdo;
    logic             clr_err;
    logic             sig_valid;
    logic             shift_done;
    logic             cap_ovr;
    logic             shift_err;

    modport master (
        output sig_capture, sig_data, bist_shift, bist_sdi, clr_err,
        input  bist_sdo, sig_valid, shift_done, cap_ovr, shift_err
    );

    modport slave (
        input  sig_capture, sig_data, bist_shift, bist_sdi, clr_err,
        output bist_sdo, sig_valid, shift_done, cap_ovr, shift_err
    );
endinterface
`default_nettype wire

// File: rtl/mbist_sig_shifter.sv
`default_nettype none
// ============================================================================
// Module      : mbist_sig_shifter
// Description : Captures a parallel BIST signature and shifts it out LSB-first
//               on a serial chain. Define MBIST_SIG_PARITY_EN to append an
//               even-parity bit that is shifted out last.
// Revision    : 1.0 - initial release
// ============================================================================
module mbist_sig_shifter #(
    parameter int SIG_W = 64
) (
    input  wire logic          mclk,
    input  wire logic          reset,
    mbist_sig_shifter_if.slave bus
);

`ifdef MBIST_SIG_PARITY_EN
    localparam int c_FRAME = SIG_W + 1;
`else
    localparam int c_FRAME = SIG_W;
`endif
    localparam int                 c_CNT_W     = $clog2(c_FRAME + 1);
    localparam logic [c_CNT_W-1:0] c_FRAME_CNT = c_CNT_W'(c_FRAME);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_LOADED = 2'd1;
    localparam logic [1:0] c_ST_SHIFT  = 2'd2;

    logic [1:0]         r_state;
    logic [c_FRAME-1:0] r_shreg;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_shift_done;
    logic               r_cap_ovr;
    logic               r_shift_err;

    logic [c_FRAME-1:0] w_load_val;
    logic [c_FRAME-1:0] w_shifted;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               w_busy;
    logic               w_framed;
    logic               w_set_ovr;
    logic               w_set_serr;

`ifdef MBIST_SIG_PARITY_EN
    assign w_load_val = {^bus.sig_data, bus.sig_data};
`else
    assign w_load_val = bus.sig_data;
`endif

    assign w_shifted = {bus.bist_sdi, r_shreg[c_FRAME-1:1]};
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_busy    = (r_state == c_ST_SHIFT);
    assign w_framed  = (r_state == c_ST_LOADED) || (r_state == c_ST_SHIFT);

    // A shift is lost when it lands on an empty register or loses to a capture.
    assign w_set_ovr  = bus.sig_capture & w_busy;
    assign w_set_serr = bus.bist_shift & ~w_busy &
                        (bus.sig_capture | (r_state != c_ST_LOADED));

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_shift_done <= 1'b0;
            r_cap_ovr    <= 1'b0;
            r_shift_err  <= 1'b0;
        end else begin
            r_shift_done <= 1'b0;
            r_cap_ovr    <= w_set_ovr  | (r_cap_ovr   & ~bus.clr_err);
            r_shift_err  <= w_set_serr | (r_shift_err & ~bus.clr_err);

            case (r_state)
                c_ST_IDLE: begin
                    if (bus.sig_capture) begin
                        r_shreg <= w_load_val;
                        r_cnt   <= '0;
                        r_state <= c_ST_LOADED;
                    end else if (bus.bist_shift) begin
                        // Pass-through: chain keeps moving, frame bookkeeping does not.
                        r_shreg <= w_shifted;
                    end
                end

                c_ST_LOADED, c_ST_SHIFT: begin
                    if (bus.sig_capture && !w_busy) begin
                        r_shreg <= w_load_val;
                        r_cnt   <= '0;
                        r_state <= c_ST_LOADED;
                    end else if (bus.bist_shift) begin
                        r_shreg <= w_shifted;
                        if (w_cnt_inc == c_FRAME_CNT) begin
                            r_cnt        <= '0;
                            r_state      <= c_ST_IDLE;
                            r_shift_done <= 1'b1;
                        end else begin
                            r_cnt   <= w_cnt_inc;
                            r_state <= c_ST_SHIFT;
                        end
                    end
                end

                default: begin
                    r_cnt   <= '0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.bist_sdo   = r_shreg[0];
    assign bus.sig_valid  = w_framed;
    assign bus.shift_done = r_shift_done;
    assign bus.cap_ovr    = r_cap_ovr;
    assign bus.shift_err  = r_shift_err;

endmodule
`default_nettype wire

// File: tb/tb_mbist_sig_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mbist_sig_shifter
// Description : Directed bench for mbist_sig_shifter: single-cycle vector
//               table plus full-frame, pause, overrun, pass-through and reset
//               sequences. Honours MBIST_SIG_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mbist_sig_shifter;

    localparam int SIG_W = 64;
`ifdef MBIST_SIG_PARITY_EN
    localparam int FRAME = SIG_W + 1;
`else
    localparam int FRAME = SIG_W;
`endif

    logic mclk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    mbist_sig_shifter_if #(.SIG_W(SIG_W)) bus ();

    mbist_sig_shifter #(.SIG_W(SIG_W)) u_dut (
        .mclk  (mclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 mclk = ~mclk;

    // {sig_valid, bist_sdo, shift_done, cap_ovr, shift_err}
    logic [4:0] w_outs;
    assign w_outs = {bus.sig_valid, bus.bist_sdo, bus.shift_done, bus.cap_ovr, bus.shift_err};

    typedef struct {
        logic        cap;
        logic [63:0] data;
        logic        shift;
        logic        sdi;
        logic        clr;
        logic [4:0]  exp;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge mclk);
        @(negedge mclk);
    endtask

    task automatic idle_inputs();
        bus.sig_capture = 1'b0;
        bus.sig_data    = '0;
        bus.bist_shift  = 1'b0;
        bus.bist_sdi    = 1'b0;
        bus.clr_err     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge mclk);
        check("reset_outs", 65'(w_outs), 65'(0));
        reset = 1'b0;
    endtask

    // Capture, shift a whole frame LSB-first, optional pause and overrun capture.
    task automatic run_frame(input logic [63:0] data, input int pause_at, input int pause_len,
                             input int cap_at, input string tag);
        logic [64:0] got;
        int          dones;
        got   = '0;
        dones = 0;
        bus.sig_data    = data;
        bus.sig_capture = 1'b1;
        step();
        bus.sig_capture = 1'b0;
        check({tag, "_cap_valid"}, 65'(bus.sig_valid), 65'(1));
        for (int i = 0; i < FRAME; i++) begin
            if (i == pause_at) begin
                for (int p = 0; p < pause_len; p++) begin
                    step();
                    dones += int'(bus.shift_done);
                end
                check({tag, "_pause_valid"}, 65'(bus.sig_valid), 65'(1));
            end
            got[i]         = bus.bist_sdo;
            bus.bist_shift = 1'b1;
            bus.bist_sdi   = 1'b0;
            if (i == cap_at) begin
                bus.sig_capture = 1'b1;
                bus.sig_data    = ~data;
            end
            step();
            bus.bist_shift  = 1'b0;
            bus.sig_capture = 1'b0;
            bus.sig_data    = data;
            if (i == cap_at)
                check({tag, "_ovr_set"}, 65'(bus.cap_ovr), 65'(1));
            if (i < FRAME - 1)
                dones += int'(bus.shift_done);
        end
        check({tag, "_done_early"}, 65'(dones), 65'(0));
        check({tag, "_done_pulse"}, 65'({bus.shift_done, bus.sig_valid}), 65'(2'b10));
        check({tag, "_word"}, 65'(got[63:0]), 65'(data));
`ifdef MBIST_SIG_PARITY_EN
        check({tag, "_parity"}, 65'(got[64]), 65'(^data));
`endif
        check({tag, "_flags"}, 65'({bus.cap_ovr, bus.shift_err}), 65'({cap_at >= 0, 1'b0}));
        step();
        check({tag, "_done_end"}, 65'(bus.shift_done), 65'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] tail;
        logic       valid_seen;

        // A5 shifts out LSB-first as 1,0,1,0,...
        vecs[0]  = '{1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 5'b00000};
        vecs[1]  = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 5'b00001};
        vecs[2]  = '{1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 5'b00000};
        vecs[3]  = '{1'b1, 64'hA5, 1'b0, 1'b0, 1'b0, 5'b11000};
        vecs[4]  = '{1'b1, 64'hA5, 1'b1, 1'b0, 1'b0, 5'b11001};
        vecs[5]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 5'b10000};
        vecs[6]  = '{1'b1, 64'h0,  1'b0, 1'b0, 1'b0, 5'b10010};
        vecs[7]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 5'b11000};
        vecs[8]  = '{1'b1, 64'hFF, 1'b1, 1'b0, 1'b1, 5'b10010};
        vecs[9]  = '{1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 5'b10010};
        vecs[10] = '{1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 5'b10000};

        idle_inputs();
        reset = 1'b1;
        @(negedge mclk);
        @(negedge mclk);
        check("por_outs", 65'(w_outs), 65'(0));
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            bus.sig_capture = vecs[i].cap;
            bus.sig_data    = vecs[i].data;
            bus.bist_shift  = vecs[i].shift;
            bus.bist_sdi    = vecs[i].sdi;
            bus.clr_err     = vecs[i].clr;
            step();
            check($sformatf("vec%0d", i), 65'(w_outs), 65'(vecs[i].exp));
        end

        do_reset();
        run_frame(64'h0123_4567_89AB_CDEF, -1, 0, -1, "cont");
        run_frame(64'hFFFF_0000_FFFF_0000, 10, 5, -1, "pause");
        run_frame(64'hDEAD_BEEF_0BAD_F00D, -1, 0, 20, "ovr");
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
        check("ovr_clr", 65'({bus.cap_ovr, bus.shift_err}), 65'(0));

        // Pass-through in IDLE: three ones walk down the chain to bist_sdo.
        do_reset();
        tail       = '0;
        valid_seen = 1'b0;
        for (int k = 1; k <= FRAME + 3; k++) begin
            bus.bist_shift = 1'b1;
            bus.bist_sdi   = (k <= 3);
            bus.clr_err    = (k == 4);
            step();
            if (k == 3)
                check("idle_err", 65'({bus.shift_err, bus.sig_valid}), 65'(2'b10));
            if (k == 4)
                check("err_set_wins", 65'(bus.shift_err), 65'(1));
            if (k >= FRAME - 1)
                tail[k-(FRAME-1)] = bus.bist_sdo;
            valid_seen |= bus.sig_valid;
        end
        idle_inputs();
        check("idle_chain", 65'(tail), 65'(5'b01110));
        check("idle_valid", 65'(valid_seen), 65'(0));

        // Asynchronous abort at bit 40, then a clean frame.
        do_reset();
        bus.sig_data    = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.sig_capture = 1'b1;
        step();
        bus.sig_capture = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus.bist_shift = 1'b1;
            step();
        end
        bus.bist_shift = 1'b0;
        check("pre_abort", 65'({bus.sig_valid, bus.bist_sdo}), 65'(2'b11));
        #2 reset = 1'b1;
        #1 check("abort_async", 65'(w_outs), 65'(0));
        @(negedge mclk);
        reset = 1'b0;
        tail = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            tail[i] = bus.shift_done | bus.sig_valid;
        end
        check("abort_quiet", 65'(tail), 65'(0));
        run_frame(64'h8421_1248_F0E1_D2C3, -1, 0, -1, "post");

`ifdef MBIST_SIG_PARITY_EN
        run_frame(64'h1, -1, 0, -1, "par1");
        run_frame(64'h3, -1, 0, -1, "par3");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
